// File: rtl/fifo_wr_arb.sv
// Write-side controller for the dual-clock FIFO: round-robin arbitration of NREQ
// requesters onto the RAM write port, write pointer ownership and fill status.
module fifo_wr_arb #(
    parameter int AWIDTH    = 3,
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 2,
    parameter int AFULL_LVL = 6
) (
    input  logic                   wr_clk_i,
    input  logic                   aclr_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ*DWIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [AWIDTH:0]        rd_pntr_gray_i,
    output logic                   mem_wr_o,
    output logic [AWIDTH-1:0]      mem_addr_o,
    output logic [DWIDTH-1:0]      mem_data_o,
    output logic [AWIDTH:0]        wr_pntr_gray_o,
    output logic                   wr_full_o,
    output logic                   wr_almost_full_o,
    output logic [AWIDTH:0]        wr_usedw_o
);

    localparam int PW = $clog2(NREQ);
    localparam logic [AWIDTH:0] DEPTH     = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0] AFULL_CMP = (AWIDTH+1)'(AFULL_LVL);

    logic [AWIDTH:0]   wr_ptr;
    logic [AWIDTH:0]   rd_bin;
    logic [PW-1:0]     prio;
    logic [NREQ-1:0]   grant;
    logic [DWIDTH-1:0] gdata;
    logic [PW-1:0]     nprio;
    logic              found;
    int unsigned       idx;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rd_bin = '0;
        for (int unsigned i = 0; i <= AWIDTH; i++) begin
            rd_bin[i] = ^(rd_pntr_gray_i >> i);
        end
    end

    assign wr_usedw_o       = wr_ptr - rd_bin;
    assign wr_full_o        = (wr_usedw_o == DEPTH);
    assign wr_almost_full_o = (wr_usedw_o >= AFULL_CMP);

    always_comb begin
        grant = '0;
        gdata = '0;
        nprio = prio;
        found = 1'b0;
        idx   = 0;
        if (!wr_full_o) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (32'(prio) + k) % NREQ;
                if (!found && req_valid_i[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gdata      = req_data_i[idx*DWIDTH +: DWIDTH];
                    nprio      = PW'((idx + 1) % NREQ);
                end
            end
        end
    end

    assign req_ready_o = grant;

    // Gray copy is taken from the pre-update pointer so it lags the RAM write.
    always_ff @(posedge wr_clk_i) begin
        if (!aclr_i) begin
            wr_ptr         <= '0;
            wr_pntr_gray_o <= '0;
            mem_wr_o       <= 1'b0;
            mem_addr_o     <= '0;
            mem_data_o     <= '0;
            prio           <= '0;
        end else begin
            wr_pntr_gray_o <= wr_ptr ^ (wr_ptr >> 1);
            mem_wr_o       <= found;
            if (found) begin
                mem_addr_o <= wr_ptr[AWIDTH-1:0];
                mem_data_o <= gdata;
                wr_ptr     <= wr_ptr + 1'b1;
                prio       <= nprio;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: reset, fill to full, release, round-robin,
// pointer wrap with a trailing reader, and reset mid-burst.
module tb_fifo_wr_arb;

    logic        wr_clk_i = 1'b0;
    logic        aclr_i = 1'b0;
    logic [1:0]  req_valid_i = '0;
    logic [15:0] req_data_i = '0;
    logic [1:0]  req_ready_o;
    logic [3:0]  rd_pntr_gray_i = '0;
    logic        mem_wr_o;
    logic [2:0]  mem_addr_o;
    logic [7:0]  mem_data_o;
    logic [3:0]  wr_pntr_gray_o;
    logic        wr_full_o;
    logic        wr_almost_full_o;
    logic [3:0]  wr_usedw_o;

    int total = 0;
    int bad   = 0;

    fifo_wr_arb #(.AWIDTH(3), .DWIDTH(8), .NREQ(2), .AFULL_LVL(6)) dut (
        .wr_clk_i(wr_clk_i), .aclr_i(aclr_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .rd_pntr_gray_i(rd_pntr_gray_i),
        .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .wr_pntr_gray_o(wr_pntr_gray_o), .wr_full_o(wr_full_o),
        .wr_almost_full_o(wr_almost_full_o), .wr_usedw_o(wr_usedw_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    function automatic logic [3:0] gray(input int unsigned b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic tick();
        @(posedge wr_clk_i);
        #1;
    endtask

    task automatic do_reset();
        aclr_i = 1'b0;
        req_valid_i = '0;
        rd_pntr_gray_i = '0;
        tick();
        aclr_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        aclr_i = 1'b0;
        tick();
        tick();
        aclr_i = 1'b1;
        tick();
        total++;
        if ({req_ready_o, wr_usedw_o, wr_full_o, wr_almost_full_o, mem_wr_o, wr_pntr_gray_o,
             mem_addr_o, mem_data_o} !== '0) begin
            bad++;
            $display("FAIL reset_state: ready=%b usedw=%0d full=%b af=%b wr=%b gray=%b addr=%0d data=%h, want all zero",
                     req_ready_o, wr_usedw_o, wr_full_o, wr_almost_full_o, mem_wr_o, wr_pntr_gray_o,
                     mem_addr_o, mem_data_o);
        end
    endtask

    task automatic test_fill();
        req_valid_i = 2'b01;
        for (int i = 0; i < 8; i++) begin
            req_data_i = {8'h00, 8'(8'h11 + i)};
            #1;
            total++;
            if (req_ready_o !== 2'b01 || wr_usedw_o !== 4'(i) || wr_almost_full_o !== (i >= 6)) begin
                bad++;
                $display("FAIL fill_status beat %0d: ready=%b usedw=%0d af=%b, want 01 %0d %b",
                         i, req_ready_o, wr_usedw_o, wr_almost_full_o, i, (i >= 6));
            end
            tick();
            total++;
            if (mem_wr_o !== 1'b1 || mem_addr_o !== 3'(i) || mem_data_o !== 8'(8'h11 + i)) begin
                bad++;
                $display("FAIL fill_write beat %0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_o, mem_addr_o, mem_data_o, i, 8'(8'h11 + i));
            end
        end
        total++;
        if (wr_usedw_o !== 4'd8 || wr_full_o !== 1'b1 || req_ready_o !== 2'b00 || wr_almost_full_o !== 1'b1) begin
            bad++;
            $display("FAIL fill_full: usedw=%0d full=%b ready=%b af=%b, want 8 1 00 1",
                     wr_usedw_o, wr_full_o, req_ready_o, wr_almost_full_o);
        end
        tick();
        total++;
        if (wr_pntr_gray_o !== 4'b1100 || mem_wr_o !== 1'b0) begin
            bad++;
            $display("FAIL fill_gray: gray=%b wr=%b, want 1100 0", wr_pntr_gray_o, mem_wr_o);
        end
    endtask

    task automatic test_release();
        req_data_i = {8'h00, 8'h5A};
        rd_pntr_gray_i = 4'b0001;
        #1;
        total++;
        if (wr_usedw_o !== 4'd7 || wr_full_o !== 1'b0 || req_ready_o !== 2'b01) begin
            bad++;
            $display("FAIL release_ready: usedw=%0d full=%b ready=%b, want 7 0 01",
                     wr_usedw_o, wr_full_o, req_ready_o);
        end
        tick();
        total++;
        if (mem_wr_o !== 1'b1 || mem_addr_o !== 3'd0 || mem_data_o !== 8'h5A || wr_full_o !== 1'b1 ||
            req_ready_o !== 2'b00) begin
            bad++;
            $display("FAIL release_write: wr=%b addr=%0d data=%h full=%b ready=%b, want 1 0 5a 1 00",
                     mem_wr_o, mem_addr_o, mem_data_o, wr_full_o, req_ready_o);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        logic [7:0] ed;
        do_reset();
        req_valid_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            req_data_i = {8'(8'hB0 + i), 8'(8'hA0 + i)};
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            ed = (i % 2 == 0) ? 8'(8'hA0 + i) : 8'(8'hB0 + i);
            #1;
            total++;
            if (req_ready_o !== eg) begin
                bad++;
                $display("FAIL alt_grant beat %0d: ready=%b, want %b", i, req_ready_o, eg);
            end
            tick();
            total++;
            if (mem_wr_o !== 1'b1 || mem_addr_o !== 3'(i) || mem_data_o !== ed) begin
                bad++;
                $display("FAIL alt_write beat %0d: wr=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_o, mem_addr_o, mem_data_o, i, ed);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        int unsigned eu;
        do_reset();
        req_valid_i = 2'b01;
        prev = '0;
        for (int unsigned i = 0; i < 20; i++) begin
            req_data_i = {8'h00, 8'(i)};
            rd_pntr_gray_i = (i >= 2) ? gray(i - 2) : 4'b0000;
            eu = (i >= 2) ? 2 : i;
            #1;
            total++;
            if (wr_usedw_o !== 4'(eu) || wr_full_o !== 1'b0 || req_ready_o !== 2'b01) begin
                bad++;
                $display("FAIL wrap_status step %0d: usedw=%0d full=%b ready=%b, want %0d 0 01",
                         i, wr_usedw_o, wr_full_o, req_ready_o, eu);
            end
            tick();
            total++;
            if (mem_addr_o !== 3'(i) || wr_pntr_gray_o !== gray(i) ||
                (i > 0 && $countones(wr_pntr_gray_o ^ prev) != 1)) begin
                bad++;
                $display("FAIL wrap_ptr step %0d: addr=%0d gray=%b prev=%b, want %0d %b",
                         i, mem_addr_o, wr_pntr_gray_o, prev, i % 8, gray(i));
            end
            prev = wr_pntr_gray_o;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid_i = 2'b11;
        req_data_i = {8'hCC, 8'h33};
        tick();
        tick();
        tick();
        aclr_i = 1'b0;
        tick();
        total++;
        if ({mem_wr_o, wr_usedw_o, wr_pntr_gray_o, mem_addr_o, mem_data_o, wr_full_o} !== '0) begin
            bad++;
            $display("FAIL midreset_state: wr=%b usedw=%0d gray=%b addr=%0d data=%h full=%b, want all zero",
                     mem_wr_o, wr_usedw_o, wr_pntr_gray_o, mem_addr_o, mem_data_o, wr_full_o);
        end
        aclr_i = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 2'b01) begin
            bad++;
            $display("FAIL midreset_prio: ready=%b, want 01", req_ready_o);
        end
        tick();
        total++;
        if (mem_wr_o !== 1'b1 || mem_addr_o !== 3'd0 || mem_data_o !== 8'h33) begin
            bad++;
            $display("FAIL midreset_resume: wr=%b addr=%0d data=%h, want 1 0 33",
                     mem_wr_o, mem_addr_o, mem_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release();
        test_alternate();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
